// File: rtl/parking_gate_sensor.sv
// parking_gate_sensor: synchronises and debounces two gate beams, then tracks
// each car's beam-break sequence to emit one inc per entry and one dec per exit.
module parking_gate_sensor #(
   parameter int DEBOUNCE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic a_raw,
   input  logic b_raw,
   output logic inc,
   output logic dec,
   output logic err,
   output logic busy,
   output logic a_filt,
   output logic b_filt
);
   typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, CLR} state_t;
   logic [1:0] sync1_q, sync_q, filt_q;
   logic [7:0] cnt_q [2];
   state_t state_q, state_d;
   logic inc_q, dec_q, err_q, busy_q, inc_d, dec_d, err_d;
   logic [1:0] ab;
   // bit 1 carries beam a, bit 0 carries beam b throughout
   assign ab = filt_q;
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync_q  <= '0;
         filt_q  <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= {a_raw, b_raw};
         sync_q  <= sync1_q;
         for (int i = 0; i < 2; i++)
            if (sync_q[i] == filt_q[i]) cnt_q[i] <= '0;
            else if (cnt_q[i] == 8'(DEBOUNCE - 1)) begin
               filt_q[i] <= sync_q[i];
               cnt_q[i]  <= '0;
            end else cnt_q[i] <= cnt_q[i] + 8'd1;
      end
   end
   always_comb begin
      state_d = state_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = ab == 2'b10 ? EN1 : ab == 2'b01 ? EX1 : ab == 2'b11 ? CLR : IDLE;
            err_d   = ab == 2'b11;
         end
         EN1: begin
            state_d = ab == 2'b11 ? EN2 : ab == 2'b00 ? IDLE : ab == 2'b01 ? CLR : EN1;
            err_d   = ab == 2'b01;
         end
         EN2: begin
            state_d = ab == 2'b01 ? EN3 : ab == 2'b10 ? EN1 : ab == 2'b00 ? CLR : EN2;
            err_d   = ab == 2'b00;
         end
         EN3: begin
            state_d = ab == 2'b00 ? IDLE : ab == 2'b11 ? EN2 : ab == 2'b10 ? CLR : EN3;
            inc_d   = ab == 2'b00;
            err_d   = ab == 2'b10;
         end
         EX1: begin
            state_d = ab == 2'b11 ? EX2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? CLR : EX1;
            err_d   = ab == 2'b10;
         end
         EX2: begin
            state_d = ab == 2'b10 ? EX3 : ab == 2'b01 ? EX1 : ab == 2'b00 ? CLR : EX2;
            err_d   = ab == 2'b00;
         end
         EX3: begin
            state_d = ab == 2'b00 ? IDLE : ab == 2'b11 ? EX2 : ab == 2'b01 ? CLR : EX3;
            dec_d   = ab == 2'b00;
            err_d   = ab == 2'b01;
         end
         CLR: state_d = ab == 2'b00 ? IDLE : CLR;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         err_q   <= err_d;
         busy_q  <= state_d != IDLE;
      end
   end
   assign inc    = inc_q;
   assign dec    = dec_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign a_filt = filt_q[1];
   assign b_filt = filt_q[0];
endmodule

// File: tb/tb_parking_gate_sensor.sv
// tb_parking_gate_sensor: table of held beam levels with expected pulse counts,
// plus hand-written glitch, latency and mid-sequence reset sequences.
module tb_parking_gate_sensor;
   logic clock = 1'b0, reset = 1'b0, a_raw = 1'b0, b_raw = 1'b0;
   logic inc, dec, err, busy, a_filt, b_filt;
   int total = 0, bad = 0;
   typedef struct {
      logic a, b;
      int ninc, ndec, nerr;
      logic busy, af, bf;
   } vec_t;
   vec_t tbl [34];
   always #5 clock = ~clock;
   parking_gate_sensor #(.DEBOUNCE(4)) dut (
      .clock(clock), .reset(reset), .a_raw(a_raw), .b_raw(b_raw),
      .inc(inc), .dec(dec), .err(err), .busy(busy), .a_filt(a_filt), .b_filt(b_filt)
   );
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic run_row(input int r);
      int ni = 0, nd = 0, ne = 0, both = 0, first_inc = 0;
      a_raw = tbl[r].a;
      b_raw = tbl[r].b;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (inc && first_inc == 0) first_inc = i;
         ni += int'(inc);
         nd += int'(dec);
         ne += int'(err);
         both += int'(inc && dec);
      end
      check($sformatf("row%0d inc", r), ni, tbl[r].ninc);
      check($sformatf("row%0d dec", r), nd, tbl[r].ndec);
      check($sformatf("row%0d err", r), ne, tbl[r].nerr);
      check($sformatf("row%0d busy", r), int'(busy), int'(tbl[r].busy));
      check($sformatf("row%0d a_filt", r), int'(a_filt), int'(tbl[r].af));
      check($sformatf("row%0d b_filt", r), int'(b_filt), int'(tbl[r].bf));
      check($sformatf("row%0d inc&dec", r), both, 0);
      if (tbl[r].ninc != 0) check($sformatf("row%0d inc latency", r), first_inc, 7);
   endtask
   initial begin
      int nf, ff, nb, np, fb, fbusy;
      tbl[0]  = '{0,0, 0,0,0, 0,0,0};
      tbl[1]  = '{1,0, 0,0,0, 1,1,0};
      tbl[2]  = '{1,1, 0,0,0, 1,1,1};
      tbl[3]  = '{0,1, 0,0,0, 1,0,1};
      tbl[4]  = '{0,0, 1,0,0, 0,0,0};
      tbl[5]  = '{0,1, 0,0,0, 1,0,1};
      tbl[6]  = '{1,1, 0,0,0, 1,1,1};
      tbl[7]  = '{1,0, 0,0,0, 1,1,0};
      tbl[8]  = '{0,0, 0,1,0, 0,0,0};
      tbl[9]  = '{1,0, 0,0,0, 1,1,0};
      tbl[10] = '{1,1, 0,0,0, 1,1,1};
      tbl[11] = '{1,0, 0,0,0, 1,1,0};
      tbl[12] = '{0,0, 0,0,0, 0,0,0};
      tbl[13] = '{1,0, 0,0,0, 1,1,0};
      tbl[14] = '{1,1, 0,0,0, 1,1,1};
      tbl[15] = '{0,1, 0,0,0, 1,0,1};
      tbl[16] = '{1,1, 0,0,0, 1,1,1};
      tbl[17] = '{0,1, 0,0,0, 1,0,1};
      tbl[18] = '{0,0, 1,0,0, 0,0,0};
      tbl[19] = '{1,0, 0,0,0, 1,1,0};
      tbl[20] = '{0,1, 0,0,1, 1,0,1};
      tbl[21] = '{1,1, 0,0,0, 1,1,1};
      tbl[22] = '{0,0, 0,0,0, 0,0,0};
      tbl[23] = '{1,1, 0,0,1, 1,1,1};
      tbl[24] = '{0,0, 0,0,0, 0,0,0};
      tbl[25] = '{0,1, 0,0,0, 1,0,1};
      tbl[26] = '{1,0, 0,0,1, 1,1,0};
      tbl[27] = '{0,0, 0,0,0, 0,0,0};
      tbl[28] = '{1,0, 0,0,0, 1,1,0};
      tbl[29] = '{1,1, 0,0,0, 1,1,1};
      tbl[30] = '{0,1, 0,0,0, 1,0,1};
      tbl[31] = '{1,1, 0,0,0, 1,1,1};
      tbl[32] = '{1,0, 0,0,0, 1,1,0};
      tbl[33] = '{0,0, 0,1,0, 0,0,0};
      tick();
      tick();
      check("reset outputs", int'({inc, dec, err, busy, a_filt, b_filt}), 0);
      reset = 1'b1;
      for (int r = 0; r <= 27; r++) run_row(r);
      // short glitch on a must be swallowed entirely
      nf = 0; nb = 0; np = 0;
      a_raw = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 3) a_raw = 1'b0;
         nf += int'(a_filt);
         nb += int'(busy);
         np += int'(inc) + int'(dec) + int'(err);
      end
      check("glitch3 a_filt cycles", nf, 0);
      check("glitch3 busy cycles", nb, 0);
      check("glitch3 pulses", np, 0);
      nf = 0; ff = 0; np = 0;
      a_raw = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 6) a_raw = 1'b0;
         if (a_filt && ff == 0) ff = i;
         nf += int'(a_filt);
         np += int'(inc) + int'(dec) + int'(err);
      end
      check("glitch6 a_filt cycles", nf, 6);
      check("glitch6 a_filt first", ff, 6);
      check("glitch6 pulses", np, 0);
      check("glitch6 busy end", int'(busy), 0);
      for (int r = 28; r <= 30; r++) run_row(r);
      reset = 1'b0;
      tick();
      check("midreset outputs", int'({inc, dec, err, busy, a_filt, b_filt}), 0);
      reset = 1'b1;
      nf = 0; fb = 0; fbusy = 0; np = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (b_filt && fb == 0) fb = i;
         if (busy && fbusy == 0) fbusy = i;
         nf += int'(a_filt);
         np += int'(inc) + int'(dec) + int'(err);
      end
      check("midreset b_filt first", fb, 6);
      check("midreset busy first", fbusy, 7);
      check("midreset a_filt cycles", nf, 0);
      check("midreset pulses", np, 0);
      for (int r = 31; r <= 33; r++) run_row(r);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
